// File: rtl/mont_sched_pkg.sv
// Shared definitions for the round-robin montgomery multiplier scheduler.
package mont_sched_pkg;

  localparam int DEFAULT_W = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mont_rr_sched_rr_pick.sv
// Rotating priority pick: first set request strictly after ptr, wrapping around.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  // Walk the rotation from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mont_rr_sched.sv
// Shares one montgomery multiplier among NREQ requesters with round-robin grant,
// sequencing the multiplier reset/start/done handshake and acking the winner.
module mont_rr_sched
  import mont_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = DEFAULT_W,
  parameter int IW   = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_m,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    rsp_data,
  output logic            busy,
  output logic [IW-1:0]   gnt_idx,
  output logic [31:0]     op_count,
  output logic            mult_rstn,
  output logic            mult_start,
  output logic [W-1:0]    mult_a,
  output logic [W-1:0]    mult_b,
  output logic [W-1:0]    mult_m,
  input  logic [W-1:0]    mult_result,
  input  logic            mult_done
);

  sched_state_e state;
  logic [IW-1:0] ptr;
  logic          pick_any;
  logic [IW-1:0] pick_idx;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] oh;
    for (int k = 0; k < NREQ; k++) oh[k] = (i == IW'(k));
    return oh;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // All outputs are registered alongside the state so none depends on req combinationally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      ack        <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      gnt_idx    <= '0;
      op_count   <= '0;
      mult_rstn  <= 1'b0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      mult_m     <= '0;
      ptr        <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx    <= pick_idx;
            mult_a     <= req_a[int'(pick_idx)*W +: W];
            mult_b     <= req_b[int'(pick_idx)*W +: W];
            mult_m     <= req_m[int'(pick_idx)*W +: W];
            busy       <= 1'b1;
            mult_rstn  <= 1'b1;
            mult_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          mult_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            rsp_data <= mult_result;
            ack      <= idx_onehot(gnt_idx);
            state    <= RESP;
          end
        end
        RESP: begin
          ack       <= '0;
          ptr       <= gnt_idx;
          op_count  <= op_count + 32'd1;
          busy      <= 1'b0;
          mult_rstn <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_rr_sched.sv
// Directed bench for mont_rr_sched with a latency-L modular-multiply stub.
module tb_mont_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IW   = 3;
  localparam int L    = 10;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_a, req_b, req_m;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    rsp_data;
  logic            busy;
  logic [IW-1:0]   gnt_idx;
  logic [31:0]     op_count;
  logic            mult_rstn, mult_start;
  logic [W-1:0]    mult_a, mult_b, mult_m;
  logic [W-1:0]    mult_result;
  logic            mult_done;

  always #5 clk = ~clk;

  mont_rr_sched #(.NREQ(NREQ), .W(W), .IW(IW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_m       (req_m),
    .ack         (ack),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .gnt_idx     (gnt_idx),
    .op_count    (op_count),
    .mult_rstn   (mult_rstn),
    .mult_start  (mult_start),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_m      (mult_m),
    .mult_result (mult_result),
    .mult_done   (mult_done)
  );

  // Multiplier stub: done (level) L cycles after the start cycle, cleared by mult_rstn.
  int   mcnt;
  logic mact;
  always @(posedge clk) begin
    if (!mult_rstn) begin
      mult_done   <= 1'b0;
      mact        <= 1'b0;
      mcnt        <= 0;
      mult_result <= '0;
    end else if (mult_start) begin
      mact <= 1'b1;
      mcnt <= 1;
    end else if (mact) begin
      if (mcnt == L - 1) begin
        mult_done   <= 1'b1;
        mact        <= 1'b0;
        mult_result <= W'((64'(mult_a) * 64'(mult_b)) % 64'(mult_m));
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int errors  = 0;
  int checks  = 0;
  int exp_ops = 0;

  typedef struct {
    int          idx;
    logic [15:0] a, b, m, rsp;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] m);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_m[i*W +: W] = m;
  endtask

  task automatic wait_ack(output logic [3:0] seen, output int n);
    seen = '0;
    n = 0;
    while (seen == 4'b0 && n < 200) begin
      tick();
      n++;
      seen = ack;
    end
  endtask

  // Wait for an ack, check it, then apply requester-side req changes around it.
  task automatic serve(input string name, input int exp_idx, input logic [15:0] exp_rsp,
                       input logic [3:0] clr, input logic [3:0] add_now, input logic [3:0] set_after);
    logic [3:0] s;
    int n;
    wait_ack(s, n);
    chk({name, " ack"}, 64'(s), 64'(1) << exp_idx);
    chk({name, " gnt_idx"}, 64'(gnt_idx), 64'(exp_idx));
    chk({name, " rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    req = (req & ~clr) | add_now;
    tick();
    exp_ops++;
    chk({name, " op_count"}, 64'(op_count), 64'(exp_ops));
    chk({name, " ack pulse"}, 64'(ack), 64'(0));
    tick();
    req = req | set_after;
  endtask

  task automatic default_ops();
    set_ops(0, 16'd3, 16'd5, 16'd7);
    set_ops(1, 16'd4, 16'd6, 16'd11);
    set_ops(2, 16'd100, 16'd200, 16'd997);
    set_ops(3, 16'd9, 16'd9, 16'd50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s;
    int n;
    int cnt;

    tbl[0] = '{idx: 0, a: 16'd7,     b: 16'd0,     m: 16'd13,    rsp: 16'd0};
    tbl[1] = '{idx: 1, a: 16'd12345, b: 16'd6789,  m: 16'd1009,  rsp: 16'd647};
    tbl[2] = '{idx: 2, a: 16'd100,   b: 16'd200,   m: 16'd997,   rsp: 16'd60};
    tbl[3] = '{idx: 3, a: 16'd65535, b: 16'd65535, m: 16'd65521, rsp: 16'd196};

    resetn = 1'b0;
    req    = '0;
    req_a  = '0;
    req_b  = '0;
    req_m  = '0;
    repeat (3) tick();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst ack", 64'(ack), 64'(0));
    chk("rst rsp_data", 64'(rsp_data), 64'(0));
    chk("rst gnt_idx", 64'(gnt_idx), 64'(0));
    chk("rst op_count", 64'(op_count), 64'(0));
    chk("rst mult_rstn", 64'(mult_rstn), 64'(0));
    chk("rst mult_start", 64'(mult_start), 64'(0));
    chk("rst mult_a", 64'(mult_a), 64'(0));
    resetn = 1'b1;
    default_ops();
    tick();

    // Single request: 3*5 mod 7 = 1, ack 12 cycles after the sampling cycle
    req = 4'b0001;
    tick();
    chk("single mult_start", 64'(mult_start), 64'(1));
    chk("single busy", 64'(busy), 64'(1));
    chk("single mult_a", 64'(mult_a), 64'(3));
    chk("single mult_m", 64'(mult_m), 64'(7));
    tick();
    chk("single start pulse", 64'(mult_start), 64'(0));
    wait_ack(s, n);
    chk("single latency", 64'(n + 2), 64'(12));
    chk("single ack", 64'(s), 64'(1));
    chk("single rsp_data", 64'(rsp_data), 64'(1));
    req = '0;
    tick();
    exp_ops = 1;
    chk("single op_count", 64'(op_count), 64'(1));
    chk("single idle busy", 64'(busy), 64'(0));
    chk("single idle mult_rstn", 64'(mult_rstn), 64'(0));

    for (int i = 0; i < 4; i++) begin
      set_ops(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].m);
      req = 4'b0001 << tbl[i].idx;
      serve($sformatf("vec%0d", i), tbl[i].idx, tbl[i].rsp, 4'b1111, 4'b0000, 4'b0000);
    end
    default_ops();

    // Contention between requesters 0 and 1
    req = 4'b0011;
    for (int j = 0; j < 4; j++) begin
      if (j < 3)
        serve($sformatf("cont%0d", j), j % 2, (j % 2 == 1) ? 16'd2 : 16'd1,
              4'b0001 << (j % 2), 4'b0000, 4'b0001 << (j % 2));
      else
        serve("cont3", 1, 16'd2, 4'b1111, 4'b0000, 4'b0000);
    end

    // Rotation fairness from reset: 1, 3, then newly added 0 beats 1
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_ops = 0;
    req = 4'b1010;
    serve("fair1", 1, 16'd2, 4'b0010, 4'b0000, 4'b0010);
    serve("fair2", 3, 16'd31, 4'b1000, 4'b0001, 4'b1000);
    serve("fair3", 0, 16'd1, 4'b1111, 4'b0000, 4'b0000);

    // Withdrawal plus operand capture: A changed after grant must not reach the multiplier
    req = 4'b0001;
    tick();
    chk("capture start mult_a", 64'(mult_a), 64'(3));
    req_a[0 +: W] = 16'd50;
    tick();
    chk("capture wait mult_a", 64'(mult_a), 64'(3));
    req = '0;
    repeat (2) tick();
    chk("withdraw busy", 64'(busy), 64'(1));
    chk("withdraw mult_a", 64'(mult_a), 64'(3));
    serve("withdraw", 0, 16'd1, 4'b1111, 4'b0000, 4'b0000);
    req_a[0 +: W] = 16'd3;

    // Single requester held high is served back-to-back
    req = 4'b0100;
    serve("b2b0", 2, 16'd60, 4'b0000, 4'b0000, 4'b0000);
    serve("b2b1", 2, 16'd60, 4'b1111, 4'b0000, 4'b0000);

    // Reset in the middle of WAIT drops the job
    req = 4'b0010;
    repeat (5) tick();
    resetn = 1'b0;
    req = '0;
    tick();
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst mult_rstn", 64'(mult_rstn), 64'(0));
    chk("midrst ack", 64'(ack), 64'(0));
    chk("midrst op_count", 64'(op_count), 64'(0));
    chk("midrst rsp_data", 64'(rsp_data), 64'(0));
    resetn = 1'b1;
    exp_ops = 0;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ack != '0) cnt++;
    end
    chk("midrst no ack", 64'(cnt), 64'(0));
    req = 4'b0010;
    serve("postrst", 1, 16'd2, 4'b1111, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_rr_sched.md
Name: mont_rr_sched

Overview:
Round-robin scheduler that shares one montgomery multiplier instance between NREQ requesters, such as ladder units or CRT halves. It arbitrates pending requests and latches the winner's operands. It then sequences the multiplier's reset/start/done protocol and returns the product with a one-cycle ack to the granted requester. It sits between the exponentiation controllers and a single multiplier to save area.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 1024, operand/result width in bits
IW, 3, width of grant index (>= clog2(NREQ))

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
req  in  NREQ  level request per requester; operands held stable while high
req_a  in  NREQ*W  operand A, requester i at slice [i*W +: W]
req_b  in  NREQ*W  operand B, same slicing
req_m  in  NREQ*W  modulus, same slicing
ack  out  NREQ  one-hot, one-cycle pulse when rsp_data is valid for that requester
rsp_data  out  W  product of last completed job; registered
busy  out  1  high in any state other than IDLE
gnt_idx  out  IW  index of current/last granted requester
op_count  out  32  completed jobs since reset; wraps at 2^32
mult_rstn  out  1  to multiplier reset (active-low); clears its done between jobs
mult_start  out  1  one-cycle start pulse to multiplier
mult_a, mult_b, mult_m  out  W each  latched operands to multiplier
mult_result  in  W  multiplier result
mult_done  in  1  multiplier done (pulse or level; first rising cycle is used)

Behaviour:
- Reset: state=IDLE; ack=0; rsp_data=0; busy=0; gnt_idx=0; op_count=0; mult_rstn=0; mult_start=0; mult_a/b/m=0; rr pointer=NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - mult_rstn=0.
  - If any req bit is set, pick the first set bit searching from (ptr+1) mod NREQ upward with wrap.
  - Latch winner index into gnt_idx and its three operand slices into mult_a/b/m.
  - Next state is START.
- START: mult_rstn=1, mult_start=1 for exactly one cycle; next state is WAIT.
- WAIT:
  - mult_rstn=1, mult_start=0.
  - On mult_done=1: rsp_data<=mult_result, next state is RESP.
  - No timeout; the block stays in WAIT until done.
- RESP:
  - ack[gnt_idx]=1 for this single cycle; rsp_data is valid.
  - ptr<=gnt_idx; op_count<=op_count+1; next state is IDLE.
- Latency: req sampled in IDLE at cycle t → mult_start at t+1 → product at t+1+L (L = multiplier latency) → ack at t+2+L. Minimum gap between consecutive jobs is 4 cycles plus L.
- ack is decoded from the registered state plus gnt_idx; no combinational path from req to ack.
- Requester side:
  - A requester drops req in the cycle after ack.
  - If req is still high when the FSM is back in IDLE, it counts as a new request.
  - Rotation still favours the other requesters.
- req changing while the FSM is not in IDLE is ignored; operands are captured only in IDLE.
- Withdrawing req after grant does not cancel the job; the ack is still issued.
- All requesters active: service order is strictly 0,1,...,NREQ-1,0,... with no starvation.
- Single requester: it is served back-to-back.
- mult_done asserted in START or IDLE is ignored.
- resetn low mid-job: returns to IDLE next edge, with every output at its reset value, mult_rstn=0, no ack, and the pending job dropped.
- op_count wraps from 0xFFFFFFFF to 0 with no flag.

Decomposition:
- Package mont_sched_pkg: FSM state localparams (IDLE=2'd0, START=2'd1, WAIT=2'd2, RESP=2'd3) and the default W.
- Sub-module rr_pick: combinational. Inputs req[NREQ] and ptr[IW]; outputs any, idx[IW]. It does the rotate-then-priority-encode and is instantiated once.

Test Plan:
- Single request: req=01, A=3, B=5, M=7, stub multiplier with L=10 returning A*B mod M → mult_start at t+1, ack=01 at t+12, rsp_data=1, op_count=1.
- Contention: req=11 held, each requester dropping req for one cycle after its ack → acks alternate 01,10,01,10 over 4 jobs; gnt_idx sequence 0,1,0,1.
- Rotation fairness with NREQ=4: req=1010 from reset → grant 1 then 3; then add req0 → next grant 0, not 1.
- Withdrawal: req0 dropped in WAIT → ack[0] still pulses; rsp_data holds the product of the latched operands.
- Reset mid-WAIT: resetn low for 1 cycle at cycle 5 of a job → next cycle busy=0, mult_rstn=0, no ack, op_count=0; a new req restarts cleanly.
- Operand capture: change req_a in START/WAIT → mult_a unchanged until the next IDLE grant.
